// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak permutation controller.
//   NUM_ROUNDS : permutation rounds per absorbed block
//   RC_W       : width of the round index (2^RC_W >= NUM_ROUNDS)
//   state_e    : controller FSM state encoding
package keccak_pkg;

  localparam int NUM_ROUNDS = 24;
  localparam int RC_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/keccak_round_cnt.sv
// Round counter for the Keccak controller.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : return the count to 0 (takes priority over inc_i)
//   inc_i      : advance the count by one
//   cnt_o      : current round number
//   last_o     : count equals NUM_ROUNDS-1
module keccak_round_cnt
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = keccak_pkg::NUM_ROUNDS,
  parameter int RC_W       = keccak_pkg::RC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [RC_W-1:0] cnt_o,
  output logic            last_o
);

  localparam logic [RC_W-1:0] LastIdx = RC_W'(NUM_ROUNDS - 1);
  localparam logic [RC_W-1:0] One     = RC_W'(1);

  logic [RC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LastIdx);

endmodule

// File: rtl/keccak_ctrl.sv
// Sequencing controller for a Keccak sponge: clears the state register on a
// new message, absorbs rate blocks, steps the round index through the
// permutation and presents the digest. Holds no datapath storage.
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a new message (honoured in IDLE only)
//   blk_valid   : rate block present (honoured in LOAD only)
//   blk_last    : presented block is the final one
//   blk_ready   : block accepted this cycle (Moore, state==LOAD)
//   dig_ready   : consumer accepts the digest
//   dig_valid   : state register holds the digest (Moore, state==DONE)
//   state_clr   : new-message clear for the state register
//   state_en    : state register load enable
//   absorb_sel  : 1 = block XOR state, 0 = round-function output
//   round_idx   : round-constant index
//   busy        : controller not idle
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start; start pulses state_clr
// LOAD     | waiting for a rate block; absorb on blk_valid
// ROUND    | one permutation round per cycle
// DONE     | digest held until dig_ready
module keccak_ctrl
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = keccak_pkg::NUM_ROUNDS,
  parameter int RC_W       = keccak_pkg::RC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            blk_valid,
  input  logic            blk_last,
  output logic            blk_ready,
  input  logic            dig_ready,
  output logic            dig_valid,
  output logic            state_clr,
  output logic            state_en,
  output logic            absorb_sel,
  output logic [RC_W-1:0] round_idx,
  output logic            busy
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   cnt_clr, cnt_inc, cnt_last;

  keccak_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RC_W       (RC_W)
  ) u_round_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (round_idx),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    state_clr  = 1'b0;
    state_en   = 1'b0;
    absorb_sel = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_clr = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (blk_valid) begin
          state_en   = 1'b1;
          absorb_sel = 1'b1;
          last_d     = blk_last;
          cnt_clr    = 1'b1;
          state_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_en = 1'b1;
        if (cnt_last) begin
          // Counter wraps to 0 here so LOAD/DONE always see round_idx==0.
          cnt_clr = 1'b1;
          state_d = last_q ? ST_DONE : ST_LOAD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (dig_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign blk_ready = (state_q == ST_LOAD);
  assign dig_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/keccak_ctrl.md
KECCAK_CTRL -- requirements
Module: keccak_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 24, meaning permutation rounds per absorbed block.
REQ-002 SHALL have parameter RC_W, default 5, meaning round_idx width; the value must satisfy 2^RC_W >= NUM_ROUNDS.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to begin a new message.
REQ-006 blk_valid  in  1  a rate block is present on the datapath input.
REQ-007 blk_last  in  1  the presented block is the final block of the message; qualified by blk_valid.
REQ-008 blk_ready  out  1  controller accepts a block this cycle.
REQ-009 dig_ready  in  1  consumer accepts the digest.
REQ-010 dig_valid  out  1  the state register holds the final digest.
REQ-011 state_clr  out  1  drives the state register's new-message clear input.
REQ-012 state_en  out  1  drives the state register's load enable.
REQ-013 absorb_sel  out  1  register-input mux select: 1 = block XOR state, 0 = round-function output.
REQ-014 round_idx  out  RC_W  current round number, used to index the round constants.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, ROUND, DONE.
REQ-017 blk_ready SHALL equal (state==LOAD), dig_valid SHALL equal (state==DONE), and busy SHALL equal (state!=IDLE); these are Moore outputs.
REQ-018 In IDLE with start=1, state_clr SHALL be 1 combinationally that cycle, and the next state SHALL be LOAD.
REQ-019 In IDLE with start=0, state_clr SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-020 In LOAD with blk_valid=1: state_en=1 and absorb_sel=1 combinationally, blk_last latched into last_q, round_idx set to 0, next state ROUND.
REQ-021 In LOAD with blk_valid=0, the FSM SHALL stay in LOAD with state_en=0.
REQ-022 In ROUND, state_en SHALL be 1 and absorb_sel SHALL be 0 every cycle; round_idx SHALL increment by 1 per cycle from 0 to NUM_ROUNDS-1.
REQ-023 In ROUND with round_idx==NUM_ROUNDS-1, the next state SHALL be DONE if last_q=1, else LOAD; round_idx SHALL return to 0 on that edge.
REQ-024 Timing: a block accepted at edge N SHALL give ROUND cycles N+1..N+NUM_ROUNDS, then blk_ready or dig_valid high from cycle N+NUM_ROUNDS+1.
REQ-025 In DONE, state_en SHALL be 0 so the digest holds; dig_valid SHALL stay high until dig_ready=1, then the next state SHALL be IDLE.
REQ-026 start SHALL be ignored outside IDLE, including when it coincides with the DONE handshake; no state_clr pulse is produced.
REQ-027 blk_valid SHALL be ignored outside LOAD; state_en SHALL be 0 in IDLE and DONE.
REQ-028 state_clr SHALL be 0 in every state other than IDLE.
REQ-029 absorb_sel SHALL be 0 whenever state_en is 0.

Reset
REQ-030 On rst_n=0 (asynchronous assert), the controller SHALL set: state=IDLE, round_idx=0, last_q=0, and every output to 0.
REQ-031 A reset asserted mid-ROUND or mid-LOAD SHALL abort the message immediately; no dig_valid SHALL follow.
REQ-032 Reset deassertion is synchronous to clk; the first start is honoured on the first rising edge after deassertion.

Structure
REQ-033 Package keccak_pkg SHALL hold NUM_ROUNDS, RC_W, and the FSM state enum type.
REQ-034 Sub-module keccak_round_cnt SHALL implement the round counter: clear, increment, and a last-round flag.
REQ-035 The controller SHALL contain no datapath storage; the state register, mux and round function sit outside it.

Verification
REQ-036 Single-block message: start at cycle 0, then blk_valid=1 with blk_last=1 at cycle 1 -> state_clr high cycle 0; state_en with absorb_sel=1 at cycle 1; round_idx 0..23 over cycles 2..25; dig_valid high from cycle 26.
REQ-037 Two-block message, blk_last=0 then 1 -> blk_ready returns in the cycle after round 23; exactly 48 ROUND cycles; dig_valid only after the second block.
REQ-038 Digest backpressure: dig_ready held low for 5 cycles in DONE -> dig_valid stays high and state_en=0 throughout; IDLE follows the cycle after dig_ready=1.
REQ-039 Reset mid-operation: rst_n pulsed low at round_idx=10 -> all outputs 0 at once; IDLE; no dig_valid.
REQ-040 Ignored start: start pulsed during ROUND and during the DONE handshake -> no state_clr; round sequence unchanged.
REQ-041 LOAD stall: blk_valid held low for 7 cycles in LOAD -> blk_ready stays high, state_en stays 0, round_idx holds 0.
